// File: rtl/i2s_pkg.sv
// Shared I2S frame geometry, sample-pair type and slot classification helper.
package i2s_pkg;

  localparam int unsigned FRAME_BITS       = 64;
  localparam int unsigned SLOT_BITS        = 32;
  localparam int unsigned LEFT_SLOT_FIRST  = 0;
  localparam int unsigned LEFT_SLOT_LAST   = 31;
  localparam int unsigned RIGHT_SLOT_FIRST = 32;
  localparam int unsigned RIGHT_SLOT_LAST  = 63;
  localparam int unsigned BIT_CNT_W        = $clog2(FRAME_BITS);

  typedef logic [SLOT_BITS-1:0] slot_word_t;

  // Samples are stored MSB-justified in a full slot word.
  typedef struct packed {
    slot_word_t lft;
    slot_word_t rght;
  } smpl_pair_t;

  typedef enum logic [1:0] {
    SEG_GUARD,
    SEG_LEFT,
    SEG_RIGHT
  } slot_seg_e;

  // Which part of the frame a bit position belongs to; the first bit of each
  // slot is the one-sclk data lag and always carries 0.
  function automatic slot_seg_e slot_seg(input logic [BIT_CNT_W-1:0] b);
    if (b == BIT_CNT_W'(LEFT_SLOT_FIRST) || b == BIT_CNT_W'(RIGHT_SLOT_FIRST))
      return SEG_GUARD;
    else if (b <= BIT_CNT_W'(LEFT_SLOT_LAST))
      return SEG_LEFT;
    else
      return SEG_RIGHT;
  endfunction

endpackage

// File: rtl/i2s_sclk_gen.sv
// Bit-clock divider: cnt runs 0..SCLK_DIV-1, sclk is high for the upper half,
// fall_evt marks the cycle whose closing edge drops sclk.
module i2s_sclk_gen #(
  parameter int unsigned SCLK_DIV = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic sclk,
  output logic fall_evt
);

  localparam int unsigned CNT_W = $clog2(SCLK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCLK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(SCLK_DIV / 2);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;

  // Wrapping divider increment.
  always_comb begin
    cnt_nxt = (cnt == CNT_LAST) ? '0 : cnt + CNT_W'(1);
  end

  // sclk and fall_evt are registered images of the next count value.
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      cnt      <= '0;
      sclk     <= 1'b0;
      fall_evt <= 1'b0;
    end else begin
      cnt      <= cnt_nxt;
      sclk     <= (cnt_nxt >= CNT_HALF);
      fall_evt <= (cnt_nxt == CNT_LAST);
    end
  end

endmodule

// File: rtl/i2s_mstr.sv
// I2S master serializer with a one-pair valid/ready holding buffer.
// Define I2S_MSTR_REPEAT_EN to repeat the last transmitted pair on underflow;
// otherwise an underflowing frame is muted (all zeros).
// With SMPL_W = 32 the left LSB would coincide with the zero bit at the
// start of the right slot and is not transmitted.
module i2s_mstr
  import i2s_pkg::*;
#(
  parameter int unsigned SCLK_DIV = 32,
  parameter int unsigned SMPL_W   = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [SMPL_W-1:0] lft_chnnl,
  input  logic [SMPL_W-1:0] rght_chnnl,
  input  logic              in_vld,
  output logic              in_rdy,
  output logic              I2S_sclk,
  output logic              I2S_ws,
  output logic              I2S_data,
  output logic              frm_strt,
  output logic              undrflw
);

  localparam logic [BIT_CNT_W-1:0] BIT_LAST = BIT_CNT_W'(RIGHT_SLOT_LAST);

  logic                 fall_evt;
  logic                 fall;
  logic                 load;
  logic                 xfer;
  logic                 hold_full;
  smpl_pair_t           hold_pair;
  smpl_pair_t           in_pair;
  smpl_pair_t           uf_pair;
  smpl_pair_t           load_pair;
  slot_word_t           sh_l;
  slot_word_t           sh_r;
  logic [BIT_CNT_W-1:0] bit_cnt;
  logic [BIT_CNT_W-1:0] bit_nxt;

  i2s_sclk_gen #(
    .SCLK_DIV(SCLK_DIV)
  ) u_sclk_gen (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .sclk    (I2S_sclk),
    .fall_evt(fall_evt)
  );

  // Frame-level events and the handshake, all derived from registered state.
  always_comb begin
    fall         = fall_evt && en;
    load         = fall && (bit_cnt == BIT_LAST);
    xfer         = in_vld && !hold_full;
    bit_nxt      = bit_cnt + BIT_CNT_W'(1);
    in_pair.lft  = slot_word_t'(lft_chnnl)  << (SLOT_BITS - SMPL_W);
    in_pair.rght = slot_word_t'(rght_chnnl) << (SLOT_BITS - SMPL_W);
    load_pair    = hold_full ? hold_pair : uf_pair;
  end

  assign in_rdy   = !hold_full;
  assign frm_strt = load;
  assign undrflw  = load && !hold_full;

  // Holding buffer: a load drains it, otherwise a transfer fills it. An empty
  // buffer at load time can be filled on that same edge for the next frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_full <= 1'b0;
      hold_pair <= '0;
    end else if (load && hold_full) begin
      hold_full <= 1'b0;
    end else if (xfer) begin
      hold_full <= 1'b1;
      hold_pair <= in_pair;
    end
  end

`ifdef I2S_MSTR_REPEAT_EN
  smpl_pair_t last_pair;

  // Remember the last pair actually taken from the buffer for replay.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_pair <= '0;
    end else if (load && hold_full) begin
      last_pair <= hold_pair;
    end
  end

  assign uf_pair = last_pair;
`else
  assign uf_pair = '0;
`endif

  // Serializer: ws, data and bit_cnt move only on fall events.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt  <= '1;
      I2S_ws   <= 1'b1;
      I2S_data <= 1'b0;
      sh_l     <= '0;
      sh_r     <= '0;
    end else if (!en) begin
      bit_cnt  <= '1;
      I2S_ws   <= 1'b1;
      I2S_data <= 1'b0;
    end else if (fall) begin
      bit_cnt <= bit_nxt;
      I2S_ws  <= bit_nxt[BIT_CNT_W-1];
      if (load) begin
        sh_l     <= load_pair.lft;
        sh_r     <= load_pair.rght;
        I2S_data <= 1'b0;
      end else if (slot_seg(bit_nxt) == SEG_LEFT) begin
        I2S_data <= sh_l[SLOT_BITS-1];
        sh_l     <= {sh_l[SLOT_BITS-2:0], 1'b0};
      end else if (slot_seg(bit_nxt) == SEG_RIGHT) begin
        I2S_data <= sh_r[SLOT_BITS-1];
        sh_r     <= {sh_r[SLOT_BITS-2:0], 1'b0};
      end else begin
        I2S_data <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_i2s_mstr.sv
// Self-checking bench for i2s_mstr: frame-level reference model, per-cycle
// compare, and an I2S receiver that reassembles slot words for literal checks.
module tb_i2s_mstr;

  localparam int unsigned DIV = 32;
  localparam int unsigned W   = 24;
`ifdef I2S_MSTR_REPEAT_EN
  localparam bit REPEAT = 1'b1;
`else
  localparam bit REPEAT = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en = 1'b0;
  logic         in_vld = 1'b0;
  logic [W-1:0] lft = '0;
  logic [W-1:0] rght = '0;
  logic         in_rdy, I2S_sclk, I2S_ws, I2S_data, frm_strt, undrflw;

  always #10 clk = ~clk;

  i2s_mstr #(.SCLK_DIV(DIV), .SMPL_W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .lft_chnnl (lft),
    .rght_chnnl(rght),
    .in_vld    (in_vld),
    .in_rdy    (in_rdy),
    .I2S_sclk  (I2S_sclk),
    .I2S_ws    (I2S_ws),
    .I2S_data  (I2S_data),
    .frm_strt  (frm_strt),
    .undrflw   (undrflw)
  );

  int vectors = 0;
  int miscompares = 0;
  bit chk_on = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // k = enabled clock edges since reset / enable; everything follows from it.
  int           k = 0;
  longint       cyc = 0;
  bit           m_full = 1'b0;
  bit           m_xfer;
  logic [W-1:0] m_hl = '0, m_hr = '0;   // holding buffer
  logic [W-1:0] m_ll = '0, m_lr = '0;   // last pair taken from the buffer
  logic [W-1:0] m_cl = '0, m_cr = '0;   // frame being transmitted

  function automatic int bitc(input int kk);
    return (63 + kk / DIV) % 64;
  endfunction

  function automatic logic frame_bit(input logic [W-1:0] l, input logic [W-1:0] r, input int b);
    if (b == 0 || b == 32) return 1'b0;
    if (b <= W) return l[W - b];
    if (b > 32 && b <= 32 + W) return r[W - (b - 32)];
    return 1'b0;
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      k = 0; m_full = 0;
      m_ll = '0; m_lr = '0; m_cl = '0; m_cr = '0;
    end else begin
      m_xfer = in_vld && !m_full;
      if (en) begin
        if (k % DIV == DIV - 1 && bitc(k) == 63) begin
          if (m_full) begin
            m_cl = m_hl; m_cr = m_hr; m_ll = m_hl; m_lr = m_hr; m_full = 0;
          end else if (REPEAT) begin
            m_cl = m_ll; m_cr = m_lr;
          end else begin
            m_cl = '0; m_cr = '0;
          end
        end
        k++;
      end else begin
        k = 0;
      end
      if (m_xfer) begin
        m_hl = lft; m_hr = rght; m_full = 1;
      end
    end
  end

  // Per-cycle compare of every output against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      automatic int  cnt = k % DIV;
      automatic int  b   = bitc(k);
      automatic bit  fs  = en && cnt == DIV - 1 && b == 63;
      check("sclk",     I2S_sclk, 64'(cnt >= DIV / 2));
      check("ws",       I2S_ws,   64'(b >= 32));
      check("data",     I2S_data, 64'(frame_bit(m_cl, m_cr, b)));
      check("frm_strt", frm_strt, 64'(fs));
      check("undrflw",  undrflw,  64'(fs && !m_full));
      check("in_rdy",   in_rdy,   64'(!m_full));
    end
  end

  // ---------------- I2S receiver ----------------
  logic [31:0] rx = '0;
  logic [31:0] lq[$];
  logic [31:0] rq[$];
  longint      wst[$];
  logic        prev_sclk = 1'b0, prev_ws = 1'b1, ws_rise = 1'b1;

  always @(negedge clk) begin
    if (I2S_ws !== prev_ws) wst.push_back(cyc);
    prev_ws = I2S_ws;
    if (rst || !en) ws_rise = 1'b1;
    if (!prev_sclk && I2S_sclk) begin
      rx = {rx[30:0], I2S_data};
      if (I2S_ws !== ws_rise) begin
        if (I2S_ws) lq.push_back(rx);
        else        rq.push_back(rx);
      end
      ws_rise = I2S_ws;
    end
    prev_sclk = I2S_sclk;
  end

  function automatic logic [31:0] qget(input logic [31:0] q[$], input int idx);
    return (idx < q.size()) ? q[idx] : 'x;
  endfunction

  function automatic longint wdiff(input int idx);
    return (idx + 1 < wst.size()) ? wst[idx+1] - wst[idx] : -1;
  endfunction

  // ---------------- stimulus ----------------
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; in_vld = 1'b0;
    tick(2);
    rst = 1'b0;
  endtask

  task automatic push(input logic [W-1:0] l, input logic [W-1:0] r);
    bit done = 1'b0;
    lft = l; rght = r; in_vld = 1'b1;
    for (int i = 0; i < 5000 && !done; i++) begin
      if (in_rdy) done = 1'b1;
      tick();
    end
    in_vld = 1'b0;
    if (!done) begin
      vectors++; miscompares++;
      $display("FAIL push_timeout: got in_rdy=0 expected in_rdy=1 within 5000 clks");
    end
  endtask

  task automatic wait_frm();
    bit ok = 1'b0;
    for (int i = 0; i < 2200 && !ok; i++) begin
      tick();
      if (frm_strt) ok = 1'b1;
    end
    if (!ok) begin
      vectors++; miscompares++;
      $display("FAIL frm_timeout: got no frm_strt expected one within 2200 clks");
    end
  endtask

  initial begin
    int la, lb, rb, wb, ld, le;
    longint c0;
    logic [W-1:0] cl_l, cl_r, d_l, d_r;
    bit rst_done;

    chk_on = 1'b1;

    // Reset release with en high: sclk / frm_strt timing, empty frame.
    en = 1'b1;
    do_reset();
    check("A_in_rdy_rst", in_rdy, 64'd1);
    tick(15);  check("A_sclk_clk15", I2S_sclk, 64'd0);
    tick();    check("A_sclk_clk16", I2S_sclk, 64'd1);
    tick(14);  check("A_frm_clk30",  frm_strt, 64'd0);
    tick();    check("A_frm_clk31",  frm_strt, 64'd1);
               check("A_uf_clk31",   undrflw,  64'd1);
    tick();    check("A_sclk_clk32", I2S_sclk, 64'd0);
               check("A_ws_clk32",   I2S_ws,   64'd0);
    la = lq.size();
    tick(2048);
    check("A_left_zero", qget(lq, la), 64'h0);

    // Pair pushed while disabled, then enabled: slot contents and ws period.
    en = 1'b0;
    do_reset();
    push(24'hA5A5A5, 24'h5A5A5A);
    lb = lq.size(); rb = rq.size(); wb = wst.size();
    en = 1'b1; c0 = cyc;
    tick(2150);
    check("B_left_slot",  qget(lq, lb),     64'hA5A5A500);
    check("B_right_slot", qget(rq, rb + 1), 64'h5A5A5A00);
    check("B_first_fall", (wb < wst.size()) ? wst[wb] - c0 : -1, 64'd32);
    check("B_ws_half1",   wdiff(wb),     64'd1024);
    check("B_ws_half2",   wdiff(wb + 1), 64'd1024);

    // Continuous stream, one pair per frame.
    cl_l = '0; cl_r = '0;
    for (int i = 0; i < 4; i++) begin
      cl_l = W'($urandom); cl_r = W'($urandom);
      push(cl_l, cl_r);
      check("C_rdy_after_push", in_rdy, 64'd0);
      wait_frm();
      check("C_no_underflow", undrflw, 64'd0);
    end

    // Push coincident with a frame load on an empty buffer.
    wait_frm();
    check("D_uf_at_push", undrflw, 64'd1);
    d_l = W'($urandom); d_r = W'($urandom);
    lft = d_l; rght = d_r; in_vld = 1'b1;
    ld = lq.size();
    tick();
    in_vld = 1'b0;
    tick(4200);
    check("D_uf_frame",   qget(lq, ld),     REPEAT ? 64'({cl_l, 8'h00}) : 64'h0);
    check("D_next_frame", qget(lq, ld + 1), 64'({d_l, 8'h00}));

    // Withheld data after a single pair.
    en = 1'b0;
    do_reset();
    push(24'h123456, 24'h654321);
    le = lq.size();
    en = 1'b1;
    wait_frm(); check("E_uf_frame0", undrflw, 64'd0);
    wait_frm(); check("E_uf_frame1", undrflw, 64'd1);
    wait_frm(); check("E_uf_frame2", undrflw, 64'd1);
    tick(1100);
    check("E_left0", qget(lq, le),     64'h12345600);
    check("E_left1", qget(lq, le + 1), REPEAT ? 64'h12345600 : 64'h0);
    check("E_left2", qget(lq, le + 2), REPEAT ? 64'h12345600 : 64'h0);

    // Random traffic, occasional disable, one reset at bit_cnt 10.
    rst_done = 1'b0;
    for (int i = 0; i < 12000; i++) begin
      in_vld = ($urandom_range(0, 999) == 0);
      lft = W'($urandom); rght = W'($urandom);
      if (i >= 2500 && !rst_done) begin
        en = 1'b1;
        if (k > 0 && bitc(k) == 10) begin
          rst = 1'b1; in_vld = 1'b0;
          tick();
          rst = 1'b0; rst_done = 1'b1;
          check("F_rst_ws",   I2S_ws,   64'd1);
          check("F_rst_sclk", I2S_sclk, 64'd0);
          check("F_rst_data", I2S_data, 64'd0);
          check("F_rst_rdy",  in_rdy,   64'd1);
          check("F_rst_frm",  frm_strt, 64'd0);
          continue;
        end
      end else if ($urandom_range(0, 2999) == 0) begin
        en = !en;
      end
      tick();
    end
    if (!rst_done) begin
      vectors++; miscompares++;
      $display("FAIL rst_mid_frame: got bit_cnt 10 never reached expected reset applied");
    end
    in_vld = 1'b0;
    tick(2);
    chk_on = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
